dbi_tx_cmd_arbiter: RTL
=======================

// Module: dbi_tx_cmd_arbiter
// PURPOSE
//  Shares one dbi_tx_phy command/data interface between NUM_REQ command sources.
//  Sources are per-display dbi_tx_fsm instances or a host command path.
//  Arbitration is round-robin and locked per packet: a packet is never interleaved.
//  Sits between the requesters and dbi_tx_phy, driving its dtf_tx_* inputs.
//  A registered output stage keeps the PHY-side timing clean at full throughput.
// PARAMETERS
//  NUM_REQ     2   number of requesters (>=2)
//  REQ_ID_W    1   width of grant index, = clog2(NUM_REQ)
//  DBI_IF_D_W  8   command type / data byte width
// PORTS
//  clk               in   1                    system clock
//  rst_n             in   1                    async reset, active low
//  req_cmd_typ_i     in   NUM_REQ*DBI_IF_D_W   per-requester command type, req k at [k*W +: W]
//  req_cmd_dat_i     in   NUM_REQ*DBI_IF_D_W   per-requester data byte
//  req_no_dat_i      in   NUM_REQ              beat is command-only (no parameter data)
//  req_last_i        in   NUM_REQ              final beat of packet
//  req_vld_i         in   NUM_REQ              beat valid
//  req_rdy_o         out  NUM_REQ              beat accepted (only granted bit can be 1)
//  dtp_tx_cmd_typ_o  out  DBI_IF_D_W           to PHY: command type
//  dtp_tx_cmd_dat_o  out  DBI_IF_D_W           to PHY: data byte
//  dtp_tx_no_dat_o   out  1                    to PHY: command-only flag
//  dtp_tx_last_o     out  1                    to PHY: last beat
//  dtp_tx_vld_o      out  1                    to PHY: beat valid
//  dtp_tx_rdy_i      in   1                    from PHY: beat accepted
//  gnt_id_o          out  REQ_ID_W             index of current/last granted requester
//  busy_o            out  1                    FSM in LOCK or output stage holds a beat
// BEHAVIOUR
//  Reset values
//  - All outputs 0. FSM = IDLE. RR pointer = NUM_REQ-1, so req0 wins first.
//  - Reset mid-packet drops the in-flight beat and the lock; no completion is generated.
//  Handshakes
//  - Valid/ready on both sides; a beat transfers when vld&&rdy at a clk rising edge.
//  - dtp_tx_* stable while dtp_tx_vld_o && !dtp_tx_rdy_i.
//  Output stage (1 entry)
//  - slot_free = !dtp_tx_vld_o || dtp_tx_rdy_i.
//  - An accepted beat loads the slot; dtp_tx_vld_o rises the next cycle.
//  - A PHY pop with no load clears dtp_tx_vld_o.
//  - Simultaneous pop and load: slot takes the new beat, vld stays 1, throughput 1 beat/clk.
//  FSM
//  - IDLE: req_rdy_o = 0. If any req_vld_i: pick first set bit scanning ptr+1, ptr+2, ...
//    (mod NUM_REQ), register gnt_id_o, go to LOCK. No request: stay in IDLE.
//  - LOCK: req_rdy_o[gnt] = slot_free; all other bits = 0.
//    An accepted beat with req_last_i[gnt] || req_no_dat_i[gnt] ends the packet:
//    ptr <= gnt, go to IDLE.
//  - A requester dropping vld mid-packet keeps the lock (no timeout); the PHY sees a gap.
//  - gnt_id_o holds its value in IDLE until the next grant.
//  Latency and ordering
//  - req vld in IDLE at cycle 0 -> req_rdy_o at cycle 1 (if slot free) -> dtp_tx_vld_o at cycle 2.
//  - Back-to-back packets incur exactly 1 idle arbitration cycle between them on the req side.
//  - Beats leave in acceptance order, unmodified; cmd_typ/dat/no_dat/last pass bit-exact.
//  Boundary conditions
//  - no_dat=1 with last=0: treated as end of packet; last is forwarded unchanged.
//  - Requesters not granted see rdy=0 and must hold their beat (AXI-style, no withdraw assumed).
//  - busy_o = (state==LOCK) || dtp_tx_vld_o.
// TESTING
//  1 Single source: req0 sends typ=0x2A dat 0x00,0x10,0x00,0xEF (last on 4th), PHY rdy=1
//    -> 4 PHY beats in order, first at cycle 2, last=1 only on 0xEF, gnt_id_o=0.
//  2 Contention: req0 and req1 both valid with 3-beat packets from reset
//    -> req0 packet fully, 1 gap cycle, then req1; then RR gives req0 priority after req1.
//  3 PHY backpressure: dtp_tx_rdy_i=0 for 5 cycles mid-packet
//    -> dtp_tx_* frozen, req_rdy_o=0 after slot fills; no beat lost or duplicated.
//  4 Command-only: req1 beat typ=0x29 no_dat=1 last=0 -> single PHY beat, FSM returns to IDLE,
//    req0 granted next.
//  5 Async reset asserted during beat 2 of 4 -> all outputs 0 immediately; after release
//    req0 wins over req1.
//  6 Random stimulus, NUM_REQ=3: scoreboard checks per-packet contiguity, bit-exact data,
//    and fairness (no requester waits >2 packets).

Source files
------------

// File: rtl/dbi_tx_cmd_arbiter_if.sv
// Handshake bundle between the command sources, dbi_tx_cmd_arbiter and dbi_tx_phy.
// slave = the arbiter; master = whatever drives the requests and the PHY ready.
interface dbi_tx_cmd_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int REQ_ID_W   = 1,
  parameter int DBI_IF_D_W = 8
);
  logic [NUM_REQ*DBI_IF_D_W-1:0] req_cmd_typ_i;
  logic [NUM_REQ*DBI_IF_D_W-1:0] req_cmd_dat_i;
  logic [NUM_REQ-1:0]            req_no_dat_i;
  logic [NUM_REQ-1:0]            req_last_i;
  logic [NUM_REQ-1:0]            req_vld_i;
  logic [NUM_REQ-1:0]            req_rdy_o;
  logic [DBI_IF_D_W-1:0]         dtp_tx_cmd_typ_o;
  logic [DBI_IF_D_W-1:0]         dtp_tx_cmd_dat_o;
  logic                          dtp_tx_no_dat_o;
  logic                          dtp_tx_last_o;
  logic                          dtp_tx_vld_o;
  logic                          dtp_tx_rdy_i;
  logic [REQ_ID_W-1:0]           gnt_id_o;
  logic                          busy_o;

  modport slave (
    input  req_cmd_typ_i, req_cmd_dat_i, req_no_dat_i, req_last_i, req_vld_i,
    output req_rdy_o,
    output dtp_tx_cmd_typ_o, dtp_tx_cmd_dat_o, dtp_tx_no_dat_o, dtp_tx_last_o, dtp_tx_vld_o,
    input  dtp_tx_rdy_i,
    output gnt_id_o, busy_o
  );

  modport master (
    output req_cmd_typ_i, req_cmd_dat_i, req_no_dat_i, req_last_i, req_vld_i,
    input  req_rdy_o,
    input  dtp_tx_cmd_typ_o, dtp_tx_cmd_dat_o, dtp_tx_no_dat_o, dtp_tx_last_o, dtp_tx_vld_o,
    output dtp_tx_rdy_i,
    input  gnt_id_o, busy_o
  );
endinterface

// File: rtl/dbi_tx_cmd_arbiter.sv
// Round-robin, packet-locked arbiter sharing one dbi_tx_phy command path between
// NUM_REQ sources, with a one-entry registered output stage toward the PHY.
module dbi_tx_cmd_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int REQ_ID_W   = 1,
  parameter int DBI_IF_D_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  dbi_tx_cmd_arbiter_if.slave bus
);
  // state | meaning
  // IDLE  | no owner; round-robin pick starting at ptr+1 when any source is valid
  // LOCK  | gnt owns the PHY path until it hands over a beat with last or no_dat
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;
  localparam int         W       = DBI_IF_D_W;

  logic [0:0]          state;
  logic [REQ_ID_W-1:0] ptr;
  logic [REQ_ID_W-1:0] gnt;
  logic [REQ_ID_W-1:0] pick;
  logic [REQ_ID_W-1:0] cand;
  logic                pick_vld;

  logic [W-1:0]        sel_typ;
  logic [W-1:0]        sel_dat;
  logic                sel_no_dat;
  logic                sel_last;
  logic                sel_vld;
  logic [NUM_REQ-1:0]  rdy;

  logic                slot_free;
  logic                accept;
  logic                eop;

  logic [W-1:0]        typ_q;
  logic [W-1:0]        dat_q;
  logic                no_dat_q;
  logic                last_q;
  logic                vld_q;

  always_comb begin
    pick     = '0;
    cand     = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = REQ_ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!pick_vld && bus.req_vld_i[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign slot_free = !vld_q || bus.dtp_tx_rdy_i;

  always_comb begin
    sel_typ    = '0;
    sel_dat    = '0;
    sel_no_dat = 1'b0;
    sel_last   = 1'b0;
    sel_vld    = 1'b0;
    rdy        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt == REQ_ID_W'(k)) begin
        sel_typ    = bus.req_cmd_typ_i[k*W +: W];
        sel_dat    = bus.req_cmd_dat_i[k*W +: W];
        sel_no_dat = bus.req_no_dat_i[k];
        sel_last   = bus.req_last_i[k];
        sel_vld    = bus.req_vld_i[k];
        rdy[k]     = (state == ST_LOCK) && slot_free;
      end
    end
  end

  assign accept = (state == ST_LOCK) && sel_vld && slot_free;
  // A command-only beat closes the packet even when last is low.
  assign eop    = sel_last || sel_no_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= REQ_ID_W'(NUM_REQ - 1);
      gnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt   <= pick;
            state <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (accept && eop) begin
            ptr   <= gnt;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Load on accept, drain on PHY pop; both in one cycle keeps 1 beat/clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      typ_q    <= '0;
      dat_q    <= '0;
      no_dat_q <= 1'b0;
      last_q   <= 1'b0;
      vld_q    <= 1'b0;
    end else if (accept) begin
      typ_q    <= sel_typ;
      dat_q    <= sel_dat;
      no_dat_q <= sel_no_dat;
      last_q   <= sel_last;
      vld_q    <= 1'b1;
    end else if (bus.dtp_tx_rdy_i) begin
      vld_q    <= 1'b0;
    end
  end

  assign bus.req_rdy_o        = rdy;
  assign bus.dtp_tx_cmd_typ_o = typ_q;
  assign bus.dtp_tx_cmd_dat_o = dat_q;
  assign bus.dtp_tx_no_dat_o  = no_dat_q;
  assign bus.dtp_tx_last_o    = last_q;
  assign bus.dtp_tx_vld_o     = vld_q;
  assign bus.gnt_id_o         = gnt;
  assign bus.busy_o           = (state == ST_LOCK) || vld_q;
endmodule
